fetch: RTL and testbench

Instruction fetch stage of the ECAP5-DPROC pipeline, sitting directly upstream of decode.
- Holds the PC and issues single-word reads on a pipelined Wishbone master port.
- Presents each fetched instruction and its PC to decode through a valid/ready handshake.
- Redirects to branch targets and to the shared boot, interrupt and debug addresses.

---
 rtl/ecap5_dproc_pkg.sv | 21 ++
 rtl/fetch.sv | 216 +++++++++++++++++++++
 tb/tb_fetch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared ECAP5-DPROC definitions: fixed redirect addresses and fetch stage types.
package ecap5_dproc_pkg;

    localparam logic [31:0] boot_address      = 32'h00000000;
    localparam logic [31:0] interrupt_address = 32'hFF00000A;
    localparam logic [31:0] debug_address     = 32'hFF00000B;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        REQUEST,
        WAIT_ACK,
        HOLD
    } fetch_state_t;

    // Word address presented on the bus for a given PC.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding pipelined Wishbone reads,
// valid/ready output to decode, and debug/interrupt/branch redirects.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misaligned_o and suppresses
// bus accesses for PCs that are not word aligned.
module fetch
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        irq_i,
    input  logic        drq_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misaligned_o
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  adr_q, adr_d;
    logic         discard_q, discard_d;
    logic         valid_q, valid_d;
    logic         stb_q, stb_d;
    logic         cyc_q, cyc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic         mis_q, mis_d;
`endif

    logic         redirect, outstanding, slot_free, issue;
    logic [31:0]  target, next_pc, issue_pc;

    // Redirect priority: debug over interrupt over branch.
    always_comb begin
        redirect = drq_i | irq_i | branch_i;
        if (drq_i) begin
            target = debug_address;
        end else if (irq_i) begin
            target = interrupt_address;
        end else begin
            target = branch_target_i;
        end
    end

    // Next-state logic for the fetch FSM and all registered outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        adr_d     = adr_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        stb_d     = stb_q;
        cyc_d     = cyc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d     = mis_q;
`endif
        next_pc   = pc_q + 32'd4;
        slot_free = ~valid_q | output_ready_i;
        issue     = 1'b0;
        issue_pc  = pc_q;
        // A request is in flight if it was accepted earlier or is accepted now.
        outstanding = ((state_q == WAIT_ACK) && !wb_ack_i) ||
                      ((state_q == REQUEST) && stb_q && !wb_stall_i);

        if (valid_q && output_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            REQUEST: begin
                if (stb_q) begin
                    if (!wb_stall_i) begin
                        state_d = WAIT_ACK;
                        stb_d   = 1'b0;
                    end
                end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (pc_q[1:0] == 2'b00) begin
                        issue = 1'b1;
                    end else if (!mis_q && slot_free) begin
                        valid_d  = 1'b1;
                        instr_d  = NOP_INSTR;
                        pc_out_d = pc_q;
                        mis_d    = 1'b1;
                    end
`else
                    issue = 1'b1;
`endif
                end
            end
            WAIT_ACK: begin
                if (wb_ack_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        issue     = 1'b1;
                    end else if (slot_free) begin
                        valid_d  = 1'b1;
                        instr_d  = wb_dat_i;
                        pc_out_d = pc_q;
                        pc_d     = next_pc;
                        issue    = 1'b1;
                        issue_pc = next_pc;
                    end else begin
                        buf_d   = wb_dat_i;
                        state_d = HOLD;
                        cyc_d   = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (output_ready_i) begin
                    valid_d  = 1'b1;
                    instr_d  = buf_q;
                    pc_out_d = pc_q;
                    pc_d     = next_pc;
                    issue    = 1'b1;
                    issue_pc = next_pc;
                end
            end
            default: ;
        endcase

        // A redirect overrides whatever the state logic chose; an in-flight
        // request is left to complete and its data is dropped via discard.
        if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_d   = 1'b0;
`endif
            if (outstanding) begin
                discard_d = 1'b1;
            end else begin
                issue    = 1'b1;
                issue_pc = target;
            end
        end

        if (issue) begin
            state_d = REQUEST;
            adr_d   = word_align(issue_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
            stb_d   = (issue_pc[1:0] == 2'b00);
            mis_d   = 1'b0;
`else
            stb_d   = 1'b1;
`endif
            cyc_d   = stb_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= REQUEST;
            pc_q      <= boot_address;
            buf_q     <= '0;
            instr_q   <= '0;
            pc_out_q  <= '0;
            adr_q     <= '0;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            adr_q     <= adr_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
            cyc_q     <= cyc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q     <= mis_d;
`endif
        end
    end

    assign output_valid_o = valid_q;
    assign instr_o        = instr_q;
    assign pc_o           = pc_out_q;
    assign wb_adr_o       = adr_q;
    assign wb_stb_o       = stb_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_we_o        = 1'b0;
    assign wb_sel_o       = 4'hF;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned_o   = mis_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: Wishbone slave returning 32'hAAAA0000+adr with a
// programmable number of extra wait cycles.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst, irq, drq, br, rdy, stall;
    logic [31:0] bt;
    logic        valid, we, stb, cyc;
    logic [31:0] instr, pc_o, adr;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic [31:0] dat = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        mis;
`endif

    int unsigned lat = 0;
    logic        pend = 1'b0;
    int unsigned cnt = 0;
    logic [31:0] padr = '0;

    int total  = 0;
    int passed = 0;

    fetch dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .irq_i          (irq),
        .drq_i          (drq),
        .branch_i       (br),
        .branch_target_i(bt),
        .output_ready_i (rdy),
        .output_valid_o (valid),
        .instr_o        (instr),
        .pc_o           (pc_o),
        .wb_adr_o       (adr),
        .wb_dat_i       (dat),
        .wb_we_o        (we),
        .wb_sel_o       (sel),
        .wb_stb_o       (stb),
        .wb_cyc_o       (cyc),
        .wb_stall_i     (stall),
        .wb_ack_i       (ack)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misaligned_o   (mis)
`endif
    );

    always #5 clk = ~clk;

    // Memory model; deliberately ignores rst so a late ack can reach the DUT.
    always @(posedge clk) begin
        ack <= 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                ack  <= 1'b1;
                dat  <= 32'hAAAA0000 + padr;
                pend <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (stb && cyc && !stall) begin
            if (lat == 0) begin
                ack <= 1'b1;
                dat <= 32'hAAAA0000 + adr;
            end else begin
                pend <= 1'b1;
                cnt  <= lat - 1;
                padr <= adr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; irq = 1'b0; drq = 1'b0; br = 1'b0; bt = '0;
        rdy = 1'b1; stall = 1'b0;
        tick(); tick();
        chk("rst valid", valid, 0);
        chk("rst instr", instr, 0);
        chk("rst pc", pc_o, 0);
        chk("rst stb", stb, 0);
        chk("rst cyc", cyc, 0);
        chk("rst adr", adr, 0);
        chk("we", we, 0);
        chk("sel", sel, 32'hF);
        rst = 1'b0;

        // First fetch from boot address
        tick();
        chk("a1 stb", stb, 1);
        chk("a1 adr", adr, 0);
        tick();
        chk("a2 stb", stb, 0);
        chk("a2 cyc", cyc, 1);
        chk("a2 valid", valid, 0);
        tick();
        chk("a3 valid", valid, 1);
        chk("a3 instr", instr, 32'hAAAA0000);
        chk("a3 pc", pc_o, 0);
        chk("a3 stb", stb, 1);
        chk("a3 adr", adr, 32'h4);

        // Stall three cycles at 0x4
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall stb", stb, 1);
            chk("stall adr", adr, 32'h4);
            chk("stall valid", valid, 0);
        end
        stall = 1'b0;
        tick();
        chk("a7 stb", stb, 0);
        chk("a7 valid", valid, 0);
        tick();
        chk("a8 valid", valid, 1);
        chk("a8 instr", instr, 32'hAAAA0004);
        chk("a8 pc", pc_o, 32'h4);
        chk("a8 adr", adr, 32'h8);

        // Decode back-pressure: word 0x8 parks in HOLD
        rdy = 1'b0;
        tick();
        chk("a9 stb", stb, 0);
        chk("a9 valid", valid, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold cyc", cyc, 0);
            chk("hold stb", stb, 0);
            chk("hold valid", valid, 1);
            chk("hold pc", pc_o, 32'h4);
            chk("hold instr", instr, 32'hAAAA0004);
        end
        rdy = 1'b1;
        tick();
        chk("a14 pc", pc_o, 32'h8);
        chk("a14 instr", instr, 32'hAAAA0008);
        chk("a14 valid", valid, 1);
        chk("a14 stb", stb, 1);
        chk("a14 adr", adr, 32'hC);

        // Branch while waiting for a slow ack
        lat = 1;
        tick();
        chk("a15 valid", valid, 0);
        chk("a15 stb", stb, 0);
        br = 1'b1; bt = 32'h100;
        tick();
        chk("a16 cyc", cyc, 1);
        chk("a16 stb", stb, 0);
        chk("a16 valid", valid, 0);
        br = 1'b0;
        tick();
        chk("a17 stb", stb, 1);
        chk("a17 adr", adr, 32'h100);
        chk("a17 valid", valid, 0);
        lat = 0;
        tick();
        chk("a18 stb", stb, 0);
        tick();
        chk("a19 valid", valid, 1);
        chk("a19 pc", pc_o, 32'h100);
        chk("a19 instr", instr, 32'hAAAA0100);
        chk("a19 adr", adr, 32'h104);

        // All redirects at once while a request is accepted: debug wins
        drq = 1'b1; irq = 1'b1; br = 1'b1; bt = 32'h200;
        tick();
        chk("a20 valid", valid, 0);
        chk("a20 stb", stb, 0);
        drq = 1'b0; irq = 1'b0; br = 1'b0;
        tick();
        chk("a21 stb", stb, 1);
        chk("a21 adr", adr, 32'hFF000008);
        chk("a21 valid", valid, 0);

        // Interrupt in the same cycle as the ack
        tick();
        irq = 1'b1;
        tick();
        chk("a23 stb", stb, 1);
        chk("a23 adr", adr, 32'hFF000008);
        chk("a23 valid", valid, 0);
        irq = 1'b0;
        tick();
        tick();
        chk("a25 valid", valid, 1);
        chk("a25 pc", pc_o, 32'hFF00000A);
        chk("a25 instr", instr, 32'hA9AA0008);

        // Branch while stalled, then PC wrap
        stall = 1'b1; br = 1'b1; bt = 32'hFFFFFFFC;
        tick();
        chk("a26 stb", stb, 1);
        chk("a26 adr", adr, 32'hFFFFFFFC);
        chk("a26 valid", valid, 0);
        br = 1'b0; stall = 1'b0;
        tick();
        tick();
        chk("a28 pc", pc_o, 32'hFFFFFFFC);
        chk("a28 instr", instr, 32'hAAA9FFFC);
        chk("a28 adr", adr, 32'h0);
        chk("a28 stb", stb, 1);

        // Reset with a request in flight; its ack lands after reset
        lat = 1;
        tick();
        rst = 1'b1;
        tick();
        chk("a30 valid", valid, 0);
        chk("a30 stb", stb, 0);
        chk("a30 cyc", cyc, 0);
        chk("a30 adr", adr, 0);
        chk("a30 pc", pc_o, 0);
        chk("a30 instr", instr, 0);
        rst = 1'b0;
        tick();
        chk("a31 stb", stb, 1);
        chk("a31 adr", adr, 0);
        chk("a31 valid", valid, 0);
        lat = 0;
        tick();
        chk("a32 stb", stb, 0);
        chk("a32 valid", valid, 0);
        tick();
        chk("a33 valid", valid, 1);
        chk("a33 pc", pc_o, 0);
        chk("a33 instr", instr, 32'hAAAA0000);
        chk("a33 adr", adr, 32'h4);

`ifdef FETCH_MISALIGN_CHECK_EN
        stall = 1'b1; br = 1'b1; bt = 32'h102;
        tick();
        chk("mis stb", stb, 0);
        br = 1'b0; stall = 1'b0;
        tick();
        chk("mis valid", valid, 1);
        chk("mis flag", mis, 1);
        chk("mis instr", instr, 32'h00000013);
        chk("mis pc", pc_o, 32'h102);
        tick();
        chk("mis idle stb", stb, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
